clz_ctrl: RTL and testbench

CLZ_CTRL -- requirements
Module: clz_ctrl

---
 rtl/clz_pkg.sv | 16 +
 rtl/clz_nib4.sv | 16 +
 rtl/clz_ctrl.sv | 110 +++++++++++
 tb/tb_clz_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/clz_pkg.sv
// Shared types and constants for the CLZ/CLO count-leading unit.
package clz_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIBBLES = 8;
  localparam int RES_W   = 32;

  localparam logic OP_CLZ = 1'b0;
  localparam logic OP_CLO = 1'b1;

endpackage

// File: rtl/clz_nib4.sv
// Combinational 4-bit leading-zero encoder; cnt is only meaningful when hit=1.
module clz_nib4 (
  input  logic [3:0] nib,
  output logic       hit,
  output logic [1:0] cnt
);

  always_comb begin
    hit = |nib;
    cnt = 2'd3;
    if (nib[3])      cnt = 2'd0;
    else if (nib[2]) cnt = 2'd1;
    else if (nib[1]) cnt = 2'd2;
  end

endmodule

// File: rtl/clz_ctrl.sv
// Multi-cycle count-leading-zeros unit, scanning one nibble per cycle from the MSB.
// Build option: define CLZ_CLO_EN to honour op (count leading ones).
//
// state | meaning
// IDLE  | waiting for start
// SCAN  | examining nibble idx of the latched operand (busy=1)
// DONE  | result valid, done pulsed; start here is accepted back-to-back
module clz_ctrl
  import clz_pkg::*;
#(
  parameter int NIBBLES = clz_pkg::NIBBLES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] idata,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] odata
);

  localparam logic [2:0] IDX_INIT = 3'(NIBBLES - 1);

  state_t      state;
  logic [2:0]  idx;
  logic [31:0] opnd;
  logic [3:0]  nib_raw;
  logic [3:0]  nib_eff;
  logic        nib_hit;
  logic [1:0]  nib_cnt;

  assign nib_raw = opnd[{idx, 2'b00} +: 4];

`ifdef CLZ_CLO_EN
  logic op_q;
  assign nib_eff = (op_q == OP_CLO) ? ~nib_raw : nib_raw;
`else
  logic unused_op;
  assign unused_op = op;
  assign nib_eff   = nib_raw;
`endif

  clz_nib4 u_nib4 (
    .nib (nib_eff),
    .hit (nib_hit),
    .cnt (nib_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= IDX_INIT;
      busy  <= 1'b0;
      done  <= 1'b0;
      odata <= '0;
      opnd  <= '0;
`ifdef CLZ_CLO_EN
      op_q  <= OP_CLZ;
`endif
    end else if (flush) begin
      // Abort wins over everything; odata keeps the last delivered result.
      state <= IDLE;
      idx   <= IDX_INIT;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            opnd  <= idata;
`ifdef CLZ_CLO_EN
            op_q  <= op;
`endif
            idx   <= IDX_INIT;
            state <= SCAN;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        SCAN: begin
          if (nib_hit) begin
            // 4*(7-idx) + cnt is just the concatenation since cnt < 4.
            odata <= RES_W'({IDX_INIT - idx, nib_cnt});
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (idx == 3'd0) begin
            odata <= RES_W'(RES_W);
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            idx <= idx - 3'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clz_ctrl.sv
// Randomised self-checking bench for clz_ctrl against a bit-level reference model.
module tb_clz_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] idata = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] odata;

  int checks = 0;
  int failures = 0;

`ifdef CLZ_CLO_EN
  localparam bit CLO_EN = 1'b1;
`else
  localparam bit CLO_EN = 1'b0;
`endif

  clz_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .idata (idata),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .odata (odata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Reference: count leading equal bits straight from the operand.
  function automatic int ref_count(input logic [31:0] d, input logic o);
    logic [31:0] eff;
    int n;
    eff = (CLO_EN && o) ? ~d : d;
    n = 0;
    for (int i = 31; i >= 0; i--) begin
      if (eff[i]) break;
      n++;
    end
    return n;
  endfunction

  function automatic int ref_lat(input int n);
    return (n == 32) ? 9 : 2 + n / 4;
  endfunction

  // Caller must be at a negedge. Returns done cycle (0 if none within budget).
  task automatic run_op(input logic [31:0] d, input logic o, input int restart_cyc,
                        input int flush_cyc, output int lat, output logic [31:0] res);
    start = 1'b1; idata = d; op = o; flush = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; idata = $urandom; op = 1'($urandom_range(0, 1));
    lat = 0; res = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (done) begin
        lat = c; res = odata;
        break;
      end
      chk("busy_during_scan", {31'd0, busy},
          (flush_cyc != 0 && c > flush_cyc) ? 32'd0 : 32'd1);
      start = (c == restart_cyc);
      if (c == restart_cyc) idata = 32'h8000_0000;
      flush = (c == flush_cyc);
    end
    start = 1'b0; flush = 1'b0;
  endtask

  task automatic do_check(input string tag, input logic [31:0] d, input logic o);
    int lat, n;
    logic [31:0] res;
    n = ref_count(d, o);
    run_op(d, o, 0, 0, lat, res);
    chk({tag, "_lat"}, lat, ref_lat(n));
    chk({tag, "_res"}, res, n);
    chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int lat;
    logic [31:0] res, prev;

    #3;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_odata", odata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_check("clz_msb", 32'h8000_0000, 1'b0);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    do_check("clz_lsb", 32'h0000_0001, 1'b0);
    do_check("clz_zero", 32'h0000_0000, 1'b0);   // back-to-back from DONE
    @(negedge clk);
    do_check("clo_fff", 32'hFFF0_0000, 1'b1);
    @(negedge clk);

    // start while busy is dropped
    run_op(32'h0001_0000, 1'b0, 2, 0, lat, res);
    chk("ignored_start_lat", lat, ref_lat(15));
    chk("ignored_start_res", res, 32'd15);
    @(negedge clk);
    chk("no_queued_op", {31'd0, busy | done}, 32'd0);

    // flush mid-scan: no done, odata retained
    prev = odata;
    run_op(32'h0000_00FF, 1'b0, 0, 3, lat, res);
    chk("flush_no_done", lat, 32'd0);
    chk("flush_odata_kept", odata, prev);

    // start and flush together: flush wins
    start = 1'b1; flush = 1'b1; idata = 32'h8000_0000;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("start_flush_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("start_flush_done", {31'd0, done}, 32'd0);

    // asynchronous reset mid-scan
    start = 1'b1; idata = 32'h0000_00FF; op = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_done", {31'd0, done}, 32'd0);
    chk("async_rst_odata", odata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_check("post_rst", 32'h0F00_0000, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] d;
      logic o;
      d = $urandom >> $urandom_range(0, 32);
      o = 1'($urandom_range(0, 1));
      if (o && $urandom_range(0, 1)) d = ~d;
      if ($urandom_range(0, 1)) repeat ($urandom_range(1, 2)) @(negedge clk);
      do_check("rand", d, o);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
